adxl362_cntrl: RTL
==================

# adxl362_cntrl

Transaction sequencer that sits directly upstream of the byte-level SPI controller and turns a single register-access request into the three-byte ADXL362 accelerometer protocol: command, address, data. It drives the controller's start / data_to_send / hold_cs inputs. It consumes the controller's busy / done / data_received outputs. It returns the read byte to the user logic above it, which is typically a button/switch-driven top level or a periodic sampler.

## Interface
- CMD_WRITE, 8'h0A, command byte issued for register writes
- CMD_READ, 8'h0B, command byte issued for register reads
- clk  input  1  system clock, shared with the SPI controller
- rst  input  1  reset, asynchronous, active-high; same net as the SPI controller's reset
- start  input  1  request a transaction; sampled only in IDLE
- write  input  1  1 = register write, 0 = register read; captured with start
- address  input  8  ADXL362 register address; captured with start
- data_to_send  input  8  write data, ignored for reads; captured with start
- busy  output  1  transaction in progress
- done  output  1  one-cycle pulse when a transaction completes
- data_received  output  8  byte returned in the third SPI byte; valid from done until the next done
- spi_start  output  1  to controller start
- spi_data_to_send  output  8  to controller data_to_send
- spi_hold_cs  output  1  to controller hold_cs (1 = keep CS low after this byte)
- spi_busy  input  1  from controller busy
- spi_done  input  1  from controller done
- spi_data_received  input  8  from controller data_received

## Operation
- States: IDLE, CMD_GO, CMD_WAIT, ADDR_GO, ADDR_WAIT, DATA_GO, DATA_WAIT, FINISH.
- IDLE: when start=1, capture write/address/data_to_send into internal registers and go to CMD_GO. start in any other state is ignored, with no queueing.
- X_GO (X = CMD, ADDR, DATA): when spi_busy=0, assert spi_start for exactly that cycle and go to X_WAIT. While spi_busy=1, stay in X_GO and keep spi_start at 0.
- X_WAIT: spi_start=0. On spi_done=1, advance: CMD_WAIT→ADDR_GO, ADDR_WAIT→DATA_GO, DATA_WAIT→FINISH.
- FINISH: done=1 for one cycle, then return to IDLE.
- spi_data_to_send by state:
  - CMD_GO and CMD_WAIT: CMD_WRITE if write=1, else CMD_READ.
  - ADDR_GO and ADDR_WAIT: captured address.
  - DATA_GO and DATA_WAIT: captured data if write=1, else 8'h00.
  - IDLE and FINISH: 8'h00.
- spi_hold_cs: 1 in CMD_* and ADDR_* states; 0 in all other states. This keeps CS low across bytes 1–2 and releases it after byte 3.
- spi_start, spi_data_to_send, spi_hold_cs, busy and done are decoded from the registered state and captured request only. They contain no combinational path from any input.
- busy = (state != IDLE).
- data_received: loaded from spi_data_received on the cycle spi_done=1 in DATA_WAIT, for reads and writes alike. Holds its value otherwise.
- spi_done in IDLE, any X_GO state or FINISH is ignored.
- Reset (any time, including mid-transaction): state→IDLE immediately. Outputs take their reset values with no further SPI bytes issued. Because the controller shares rst, it also aborts, and CS returns high.

## Timing
- Reset values:
  - busy=0, done=0, data_received=8'h00
  - spi_start=0, spi_data_to_send=8'h00, spi_hold_cs=0
  - internal captured registers=0
- Request latency:
  - start sampled at edge N; busy=1 from N+1.
  - spi_start=1 during cycle N+1 when spi_busy=0.
- Inter-byte gap: spi_done at edge M → X_GO entered at M+1 → next spi_start at cycle M+1, if the controller has dropped busy.
- Completion: spi_done for the data byte at edge K → done=1 and data_received valid in cycle K+1 → busy=0 from K+2.
- A new start is accepted in the cycle busy first reads 0, so back-to-back transactions are allowed.
- spi_data_to_send and spi_hold_cs are stable from the spi_start cycle through that byte's spi_done.

## Test plan
- Read of register 0x00 (bench SPI-controller model returns 0xAD on the third byte) → bytes issued 0x0B, 0x00, 0x00. spi_hold_cs=1,1,0. data_received=0xAD with a single done pulse. Busy falls the cycle after done.
- Write 0x52 to register 0x2D → bytes 0x0A, 0x2D, 0x52 with hold_cs 1,1,0. Exactly three spi_start pulses and one done pulse.
- start pulsed repeatedly during a transaction → still only three spi_start pulses, and captured address/data are unchanged.
- Controller model holds spi_busy=1 for 5 extra cycles after each spi_done → spi_start is withheld until spi_busy=0, and each spi_start is exactly one cycle wide.
- rst asserted during ADDR_WAIT → busy, spi_start and spi_hold_cs go to 0 immediately, and data_received=0x00. A following read of 0x01 completes normally.
- Two reads back-to-back (start asserted the cycle busy falls) → second transaction begins at once, and data_received updates at each done.

Source files
------------

// File: rtl/adxl362_cntrl.sv
// ADXL362 register-access sequencer: expands one request into the command/address/data
// byte sequence for the downstream byte-level SPI controller.
`timescale 1ns/1ps
module adxl362_cntrl #(
  parameter logic [7:0] CMD_WRITE = 8'h0A,
  parameter logic [7:0] CMD_READ  = 8'h0B
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       write,
  input  logic [7:0] address,
  input  logic [7:0] data_to_send,
  output logic       busy,
  output logic       done,
  output logic [7:0] data_received,
  output logic       spi_start,
  output logic [7:0] spi_data_to_send,
  output logic       spi_hold_cs,
  input  logic       spi_busy,
  input  logic       spi_done,
  input  logic [7:0] spi_data_received
);

  typedef enum logic [2:0] {
    IDLE,
    CMD_GO,
    CMD_WAIT,
    ADDR_GO,
    ADDR_WAIT,
    DATA_GO,
    DATA_WAIT,
    FINISH
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic       r_start;
  logic       w_next_is_go;
  logic       r_write;
  logic [7:0] r_address;
  logic [7:0] r_data;
  logic [7:0] r_data_received;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:      if (start)    w_next_state = CMD_GO;
      CMD_GO:    if (r_start)  w_next_state = CMD_WAIT;
      CMD_WAIT:  if (spi_done) w_next_state = ADDR_GO;
      ADDR_GO:   if (r_start)  w_next_state = ADDR_WAIT;
      ADDR_WAIT: if (spi_done) w_next_state = DATA_GO;
      DATA_GO:   if (r_start)  w_next_state = DATA_WAIT;
      DATA_WAIT: if (spi_done) w_next_state = FINISH;
      FINISH:                  w_next_state = IDLE;
      default:                 w_next_state = IDLE;
    endcase
  end

  assign w_next_is_go = (w_next_state == CMD_GO) || (w_next_state == ADDR_GO) ||
                        (w_next_state == DATA_GO);

  // spi_start is a register: the controller's busy is sampled one edge ahead so the
  // strobe has no combinational path from spi_busy yet still fires on the first GO cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_start <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_start <= w_next_is_go && !spi_busy;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_write         <= 1'b0;
      r_address       <= '0;
      r_data          <= '0;
      r_data_received <= '0;
    end else begin
      if (r_state == IDLE && start) begin
        r_write   <= write;
        r_address <= address;
        r_data    <= data_to_send;
      end
      if (r_state == DATA_WAIT && spi_done)
        r_data_received <= spi_data_received;
    end
  end

  always_comb begin
    spi_data_to_send = '0;
    spi_hold_cs      = 1'b0;
    case (r_state)
      CMD_GO, CMD_WAIT: begin
        spi_data_to_send = r_write ? CMD_WRITE : CMD_READ;
        spi_hold_cs      = 1'b1;
      end
      ADDR_GO, ADDR_WAIT: begin
        spi_data_to_send = r_address;
        spi_hold_cs      = 1'b1;
      end
      DATA_GO, DATA_WAIT: begin
        spi_data_to_send = r_write ? r_data : 8'h00;
      end
      default: begin
        spi_data_to_send = '0;
        spi_hold_cs      = 1'b0;
      end
    endcase
  end

  assign spi_start     = r_start;
  assign busy          = (r_state != IDLE);
  assign done          = (r_state == FINISH);
  assign data_received = r_data_received;

endmodule
